// File: rtl/l1_miss_arbiter.sv
// l1_miss_arbiter: sequences L1 I-cache and D-cache line refills over one
// shared 128-bit memory port. Misses are granted round-robin from IDLE. A
// dirty D-cache victim is written back before the fill. The owner's update
// strobe then pulses once with the registered fill line.
// Optional build macro MISS_PERF_CNT_EN adds saturating grant/write-back
// counters (i_miss_cnt, d_miss_cnt, wb_cnt).
//
// Memory handshake: mem_req rises with a transaction and holds, together with
// mem_we/mem_addr/mem_wdata, until the cycle in which mem_ack is sampled
// high. mem_ack is a one-cycle pulse, and mem_rdata is valid in that cycle.
// An ack outside WB/FILL is ignored.
module l1_miss_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h11000000,
    parameter int          LINE_W  = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_miss,
    input  logic [31:0]       i_addr,
    output logic              i_update,
    output logic              i_stall,
    input  logic              d_miss,
    input  logic [31:0]       d_addr,
    input  logic              d_victim_dirty,
    input  logic [31:0]       d_victim_addr,
    input  logic [LINE_W-1:0] d_victim_line,
    output logic              d_update,
    output logic              d_stall,
    output logic [LINE_W-1:0] fill_line,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
`ifdef MISS_PERF_CNT_EN
   ,output logic [31:0]       i_miss_cnt,
    output logic [31:0]       d_miss_cnt,
    output logic [31:0]       wb_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_FILL  = 3'd2,
        S_UPD   = 3'd3,
        S_RECOV = 3'd4
    } state_e;

    // Owner / last_grant encoding: 0 = I-cache, 1 = D-cache.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [31:0]        victim_addr_q, victim_addr_d;
    logic [LINE_W-1:0]  victim_line_q, victim_line_d;
    logic [LINE_W-1:0]  fill_line_q, fill_line_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               i_update_q, i_update_d;
    logic               d_update_q, d_update_d;

    logic               ireq, dreq;
    logic               pick_d;
    logic [31:0]        sel_addr;

    // IO-space data accesses are uncached and never take part in arbitration.
    assign ireq = i_miss;
    assign dreq = d_miss && (d_addr < IO_BASE);

    // Next-state, grant/latch decisions and the registered Moore outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        miss_addr_d   = miss_addr_q;
        victim_addr_d = victim_addr_q;
        victim_line_d = victim_line_q;
        fill_line_d   = fill_line_q;
        pick_d        = 1'b0;
        sel_addr      = i_addr;

        case (state_q)
            S_IDLE: begin
                if (ireq || dreq) begin
                    // On a tie the side that did not win last time is served.
                    pick_d        = dreq && (!ireq || (last_grant_q == OWN_I));
                    sel_addr      = pick_d ? d_addr : i_addr;
                    owner_d       = pick_d;
                    last_grant_d  = pick_d;
                    miss_addr_d   = sel_addr & ~32'hF;
                    victim_addr_d = d_victim_addr & ~32'hF;
                    victim_line_d = d_victim_line;
                    state_d       = (pick_d && d_victim_dirty) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) state_d = S_FILL;
            end
            S_FILL: begin
                if (mem_ack) begin
                    fill_line_d = mem_rdata;
                    state_d     = S_UPD;
                end
            end
            S_UPD:   state_d = S_RECOV;
            S_RECOV: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_req_d   = (state_d == S_WB) || (state_d == S_FILL);
        mem_we_d    = (state_d == S_WB);
        mem_addr_d  = (state_d == S_WB)   ? victim_addr_d :
                      (state_d == S_FILL) ? miss_addr_d   : 32'h0;
        mem_wdata_d = (state_d == S_WB)   ? victim_line_d : '0;
        i_update_d  = (state_d == S_UPD) && (owner_d == OWN_I);
        d_update_d  = (state_d == S_UPD) && (owner_d == OWN_D);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_I;
            last_grant_q  <= OWN_I;
            miss_addr_q   <= 32'h0;
            victim_addr_q <= 32'h0;
            victim_line_q <= '0;
            fill_line_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= '0;
            i_update_q    <= 1'b0;
            d_update_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            miss_addr_q   <= miss_addr_d;
            victim_addr_q <= victim_addr_d;
            victim_line_q <= victim_line_d;
            fill_line_q   <= fill_line_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            i_update_q    <= i_update_d;
            d_update_q    <= d_update_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign fill_line = fill_line_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_update  = i_update_q;
    assign d_update  = d_update_q;

    // Stalls cover the raw request and the owner's whole service, including
    // UPD and RECOV. They are forced low while RESET is held.
    assign i_stall = !RESET && (ireq || ((owner_q == OWN_I) && busy));
    assign d_stall = !RESET && (dreq || ((owner_q == OWN_D) && busy));

`ifdef MISS_PERF_CNT_EN
    logic [31:0] i_cnt_q, d_cnt_q, wb_cnt_q;
    logic        grant_any;
    logic        wb_entry;

    assign grant_any = (state_q == S_IDLE) && (state_d != S_IDLE);
    assign wb_entry  = (state_d == S_WB) && (state_q != S_WB);

    // Saturating event counters, cleared only by RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            i_cnt_q  <= 32'h0;
            d_cnt_q  <= 32'h0;
            wb_cnt_q <= 32'h0;
        end else begin
            if (grant_any && (owner_d == OWN_I) && (i_cnt_q != 32'hFFFFFFFF))
                i_cnt_q <= i_cnt_q + 32'd1;
            if (grant_any && (owner_d == OWN_D) && (d_cnt_q != 32'hFFFFFFFF))
                d_cnt_q <= d_cnt_q + 32'd1;
            if (wb_entry && (wb_cnt_q != 32'hFFFFFFFF))
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign i_miss_cnt = i_cnt_q;
    assign d_miss_cnt = d_cnt_q;
    assign wb_cnt     = wb_cnt_q;
`endif

endmodule

// File: tb/tb_l1_miss_arbiter.sv
// Testbench for l1_miss_arbiter: directed timing scenarios plus randomized
// miss mixes against a transaction-level model of grants and memory traffic.
module tb_l1_miss_arbiter;
    localparam logic [31:0] IO_BASE = 32'h11000000;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         i_miss, d_miss, d_victim_dirty, mem_ack;
    logic [31:0]  i_addr, d_addr, d_victim_addr;
    logic [127:0] d_victim_line, mem_rdata;
    logic         i_update, i_stall, d_update, d_stall, mem_req, mem_we, busy;
    logic [31:0]  mem_addr;
    logic [127:0] fill_line, mem_wdata;
`ifdef MISS_PERF_CNT_EN
    logic [31:0]  i_miss_cnt, d_miss_cnt, wb_cnt;
`endif

    l1_miss_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .i_miss(i_miss), .i_addr(i_addr), .i_update(i_update), .i_stall(i_stall),
        .d_miss(d_miss), .d_addr(d_addr), .d_victim_dirty(d_victim_dirty),
        .d_victim_addr(d_victim_addr), .d_victim_line(d_victim_line),
        .d_update(d_update), .d_stall(d_stall), .fill_line(fill_line),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
`ifdef MISS_PERF_CNT_EN
       ,.i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    // Clock: 10 time units per cycle; the bench drives and samples on negedges.
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model state: expected memory transactions {we, addr, wdata}, expected
    // update owners (1 = D), last granted side, and the last line read.
    logic [160:0] exp_mem_q[$];
    logic         exp_own_q[$];
    logic         model_last;
    logic [127:0] last_rdata;

    task automatic do_reset();
        RESET = 1'b1;
        i_miss = 0; d_miss = 0; d_victim_dirty = 0; mem_ack = 0;
        i_addr = 0; d_addr = 0; d_victim_addr = 0; d_victim_line = 0; mem_rdata = 0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_last = 1'b0;
        exp_mem_q.delete();
        exp_own_q.delete();
        @(negedge CLK);
    endtask

    // Predict service order and memory traffic for the misses now driven.
    task automatic plan(input bit i_on, input bit d_on);
        logic order[$];
        logic own;
        if (i_on && d_on) begin
            order.push_back(!model_last);
            order.push_back(model_last);
        end else if (i_on) order.push_back(1'b0);
        else if (d_on) order.push_back(1'b1);
        while (order.size() > 0) begin
            own = order.pop_front();
            exp_own_q.push_back(own);
            if (own) begin
                if (d_victim_dirty)
                    exp_mem_q.push_back({1'b1, d_victim_addr & ~32'hF, d_victim_line});
                exp_mem_q.push_back({1'b0, d_addr & ~32'hF, 128'h0});
            end else begin
                exp_mem_q.push_back({1'b0, i_addr & ~32'hF, 128'h0});
            end
            model_last = own;
        end
    endtask

    // Act as memory and caches until the planned services are finished.
    task automatic run_mem(input int max_cycles, input bit drop_first);
        int n;
        int wait_n = 0;
        bit txn_open = 0;
        bit in_svc = 0;
        logic cur_own = 0;
        logic [160:0] exp;
        for (n = 0; n < max_cycles; n++) begin
            @(negedge CLK);
            if (mem_ack) mem_ack = 1'b0;
            if (!busy) in_svc = 0;
            else if (!in_svc) begin
                in_svc = 1;
                cur_own = (exp_own_q.size() > 0) ? exp_own_q[0] : 1'b0;
            end
            checks++;
            if (i_stall !== (i_miss || (in_svc && !cur_own))) begin
                errors++; $display("FAIL run_i_stall got %0b exp %0b", i_stall, i_miss || (in_svc && !cur_own));
            end
            checks++;
            if (d_stall !== ((d_miss && d_addr < IO_BASE) || (in_svc && cur_own))) begin
                errors++; $display("FAIL run_d_stall got %0b exp %0b", d_stall, (d_miss && d_addr < IO_BASE) || (in_svc && cur_own));
            end
            if (i_update || d_update) begin
                checks++;
                if (exp_own_q.size() == 0 || (i_update && d_update) ||
                    d_update !== exp_own_q[0] || fill_line !== last_rdata) begin
                    errors++;
                    $display("FAIL run_update got i=%0b d=%0b line=%h exp owner_d=%0b line=%h",
                             i_update, d_update, fill_line,
                             (exp_own_q.size() > 0) ? exp_own_q[0] : 1'bx, last_rdata);
                end
                if (exp_own_q.size() > 0) void'(exp_own_q.pop_front());
                if (d_update) d_miss = 1'b0; else i_miss = 1'b0;
            end
            if (mem_req) begin
                if (!txn_open) begin
                    txn_open = 1;
                    wait_n = $urandom_range(0, 3);
                    checks++;
                    if (exp_mem_q.size() == 0) begin
                        errors++; $display("FAIL run_mem_txn unexpected we=%0b addr=%h", mem_we, mem_addr);
                    end else begin
                        exp = exp_mem_q.pop_front();
                        if (mem_we !== exp[160] || mem_addr !== exp[159:128] ||
                            (exp[160] && mem_wdata !== exp[127:0])) begin
                            errors++;
                            $display("FAIL run_mem_txn got we=%0b addr=%h wdata=%h exp we=%0b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, exp[160], exp[159:128], exp[127:0]);
                        end
                    end
                end
                if (wait_n == 0) begin
                    mem_ack = 1'b1;
                    if (!mem_we) begin
                        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                        last_rdata = mem_rdata;
                    end
                    txn_open = 0;
                end else wait_n--;
            end
            if (drop_first && n == 0) begin
                i_miss = 1'b0; d_miss = 1'b0;
            end
            if (!busy && !mem_ack && exp_mem_q.size() == 0 && exp_own_q.size() == 0) break;
        end
        checks++;
        if (busy || exp_mem_q.size() != 0 || exp_own_q.size() != 0) begin
            errors++;
            $display("FAIL run_mem_incomplete busy=%0b left_txn=%0d left_upd=%0d after %0d cycles",
                     busy, exp_mem_q.size(), exp_own_q.size(), n);
        end
        exp_mem_q.delete();
        exp_own_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, mem_req, mem_we, i_update, d_update, i_stall, d_stall} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000000",
                               {busy, mem_req, mem_we, i_update, d_update, i_stall, d_stall});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 128'h0 || fill_line !== 128'h0) begin
            errors++; $display("FAIL reset_data got addr=%h wdata=%h line=%h exp 0", mem_addr, mem_wdata, fill_line);
        end
    endtask

    task automatic test_clean_i();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        i_addr = 32'h00000104; i_miss = 1'b1;
        @(negedge CLK);
        checks++;
        if (!(busy === 1 && mem_req === 1 && mem_we === 0 && mem_addr === 32'h100 && i_stall === 1)) begin
            errors++; $display("FAIL clean_i_req got busy=%0b req=%0b we=%0b addr=%h stall=%0b exp 1 1 0 00000100 1",
                               busy, mem_req, mem_we, mem_addr, i_stall);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            checks++;
            if (mem_req !== 1'b1 || i_update !== 1'b0) begin
                errors++; $display("FAIL clean_i_hold got req=%0b upd=%0b exp 1 0", mem_req, i_update);
            end
        end
        mem_ack = 1'b1; mem_rdata = r;
        @(negedge CLK);
        mem_ack = 1'b0;
        checks++;
        if (!(i_update === 1 && d_update === 0 && fill_line === r && mem_req === 0 && busy === 1)) begin
            errors++; $display("FAIL clean_i_upd got iu=%0b du=%0b line=%h req=%0b busy=%0b exp 1 0 %h 0 1",
                               i_update, d_update, fill_line, mem_req, busy, r);
        end
        i_miss = 1'b0;
        @(negedge CLK);
        checks++;
        if (!(i_update === 0 && busy === 1 && i_stall === 1 && fill_line === r)) begin
            errors++; $display("FAIL clean_i_recov got iu=%0b busy=%0b stall=%0b exp 0 1 1", i_update, busy, i_stall);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || i_stall !== 1'b0) begin
            errors++; $display("FAIL clean_i_done got busy=%0b stall=%0b exp 0 0", busy, i_stall);
        end
        model_last = 1'b0;
    endtask

    task automatic test_dirty_d();
        logic [127:0] v, r;
        v = {$urandom, $urandom, $urandom, $urandom};
        r = {$urandom, $urandom, $urandom, $urandom};
        d_addr = 32'h00000230; d_victim_addr = 32'h00004230; d_victim_line = v;
        d_victim_dirty = 1'b1; d_miss = 1'b1;
        @(negedge CLK);
        checks++;
        if (!(mem_req === 1 && mem_we === 1 && mem_addr === 32'h4230 && mem_wdata === v && d_stall === 1)) begin
            errors++; $display("FAIL dirty_wb got req=%0b we=%0b addr=%h wdata=%h stall=%0b exp 1 1 00004230 %h 1",
                               mem_req, mem_we, mem_addr, mem_wdata, d_stall, v);
        end
        @(negedge CLK);
        mem_ack = 1'b1;
        @(negedge CLK);
        mem_ack = 1'b0;
        checks++;
        if (!(mem_req === 1 && mem_we === 0 && mem_addr === 32'h230)) begin
            errors++; $display("FAIL dirty_fill got req=%0b we=%0b addr=%h exp 1 0 00000230", mem_req, mem_we, mem_addr);
        end
        @(negedge CLK);
        mem_ack = 1'b1; mem_rdata = r;
        @(negedge CLK);
        mem_ack = 1'b0;
        checks++;
        if (!(d_update === 1 && i_update === 0 && fill_line === r && mem_req === 0)) begin
            errors++; $display("FAIL dirty_upd got du=%0b iu=%0b line=%h req=%0b exp 1 0 %h 0",
                               d_update, i_update, fill_line, mem_req, r);
        end
        d_miss = 1'b0; d_victim_dirty = 1'b0;
        @(negedge CLK);
        checks++;
        if (d_update !== 1'b0 || busy !== 1'b1 || d_stall !== 1'b1) begin
            errors++; $display("FAIL dirty_recov got du=%0b busy=%0b stall=%0b exp 0 1 1", d_update, busy, d_stall);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || d_stall !== 1'b0) begin
            errors++; $display("FAIL dirty_done got busy=%0b stall=%0b exp 0 0", busy, d_stall);
        end
        model_last = 1'b1;
    endtask

    task automatic test_io();
        logic [31:0] io_addrs[3];
        io_addrs[0] = 32'h11000004; io_addrs[1] = 32'h11000000; io_addrs[2] = 32'hFFFFFFF0;
        for (int a = 0; a < 3; a++) begin
            d_addr = io_addrs[a]; d_miss = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                checks++;
                if (mem_req !== 1'b0 || busy !== 1'b0 || d_stall !== 1'b0) begin
                    errors++; $display("FAIL io_ignore addr=%h got req=%0b busy=%0b stall=%0b exp 0 0 0",
                                       d_addr, mem_req, busy, d_stall);
                end
            end
            d_miss = 1'b0;
        end
        // Highest cached line just below the IO window.
        d_addr = 32'h10FFFFFC; d_victim_dirty = 1'b0; d_miss = 1'b1;
        plan(1'b0, 1'b1);
        run_mem(60, 1'b0);
    endtask

    task automatic test_reset_mid();
        i_addr = 32'h00000300; i_miss = 1'b1;
        @(negedge CLK);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            errors++; $display("FAIL rstmid_fill got req=%0b addr=%h exp 1 00000300", mem_req, mem_addr);
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if ({busy, mem_req, mem_we, i_update, d_update, i_stall, d_stall} !== 7'b0 ||
            mem_addr !== 32'h0 || fill_line !== 128'h0 || mem_wdata !== 128'h0) begin
            errors++; $display("FAIL rstmid_async got ctrl=%b addr=%h line=%h exp all 0",
                               {busy, mem_req, mem_we, i_update, d_update, i_stall, d_stall}, mem_addr, fill_line);
        end
        i_miss = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        model_last = 1'b0;
        @(negedge CLK);
        mem_ack = 1'b1; mem_rdata = 128'hDEAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            mem_ack = 1'b0;
            checks++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || i_update !== 1'b0 || d_update !== 1'b0) begin
                errors++; $display("FAIL rstmid_late_ack got busy=%0b req=%0b iu=%0b du=%0b exp 0 0 0 0",
                                   busy, mem_req, i_update, d_update);
            end
        end
        d_addr = $urandom_range(0, 32'h10FFFFFF); d_victim_dirty = 1'b0; d_miss = 1'b1;
        plan(1'b0, 1'b1);
        run_mem(60, 1'b0);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            i_addr = $urandom; d_addr = $urandom_range(0, 32'h10FFFFFF);
            d_victim_dirty = $urandom_range(0, 1);
            d_victim_addr = $urandom; d_victim_line = {$urandom, $urandom, $urandom, $urandom};
            i_miss = 1'b1; d_miss = 1'b1;
            plan(1'b1, 1'b1);
            run_mem(100, 1'b0);
        end
    endtask

    task automatic test_drop_miss();
        d_addr = $urandom_range(0, 32'h10FFFFFF);
        d_victim_dirty = 1'b1; d_victim_addr = $urandom;
        d_victim_line = {$urandom, $urandom, $urandom, $urandom};
        d_miss = 1'b1;
        plan(1'b0, 1'b1);
        run_mem(60, 1'b1);
        d_victim_dirty = 1'b0;
    endtask

    task automatic test_random();
        bit i_on;
        int d_kind;
        for (int it = 0; it < 30; it++) begin
            i_on = $urandom_range(0, 1);
            d_kind = $urandom_range(0, 2);
            i_addr = $urandom;
            d_addr = (d_kind == 2) ? IO_BASE + $urandom_range(0, 32'h0EFFFFFF)
                                   : $urandom_range(0, 32'h10FFFFFF);
            d_victim_dirty = $urandom_range(0, 1);
            d_victim_addr = $urandom;
            d_victim_line = {$urandom, $urandom, $urandom, $urandom};
            i_miss = i_on;
            d_miss = (d_kind != 0);
            plan(i_on, d_kind == 1);
            run_mem(100, 1'b0);
            i_miss = 1'b0; d_miss = 1'b0;
            @(negedge CLK);
        end
    endtask

`ifdef MISS_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            i_addr = $urandom; d_addr = $urandom_range(0, 32'h10FFFFFF);
            d_victim_addr = $urandom; d_victim_line = {$urandom, $urandom, $urandom, $urandom};
            d_victim_dirty = (k == 4);
            i_miss = (k < 3); d_miss = (k >= 3);
            plan(k < 3, k >= 3);
            run_mem(60, 1'b0);
        end
        checks++;
        if (i_miss_cnt !== 32'd3 || d_miss_cnt !== 32'd2 || wb_cnt !== 32'd1) begin
            errors++; $display("FAIL perf_cnt got i=%0d d=%0d wb=%0d exp 3 2 1", i_miss_cnt, d_miss_cnt, wb_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_i();
        test_dirty_d();
        test_io();
        test_reset_mid();
        test_round_robin();
        test_drop_miss();
        test_random();
`ifdef MISS_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck DUT cannot hang the run.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
